// File: rtl/pulse_rate_meter.sv
// pulse_rate_meter
//
// Measures the rising-to-rising period of a slow, asynchronous square wave
// (for example a divided blink clock) in clk cycles and classifies it as the
// fast rate, the slow rate, or out of range. Loss of signal is flagged when no
// rising edge arrives for TIMEOUT cycles.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   sig_in       measured square wave, asynchronous to clk
//   period       last measured rising-to-rising period, in clk cycles
//   period_valid one-cycle strobe when period and rate update
//   rate         00 none, 01 fast, 10 slow, 11 out of range
//   lost         high while no rising edge has been seen for TIMEOUT cycles
//
// Output handshake: period_valid is a pure strobe with no ready/back-pressure.
// It is high for exactly one clk cycle per measured rising edge, and period
// and rate are stable from that cycle until the next strobe (or until rate
// drops to 00 on entry to loss). A consumer must sample on the strobe.

module pulse_rate_meter #(
    parameter int CNT_W       = 28,
    parameter int FAST_PERIOD = 12_500_002,
    parameter int SLOW_PERIOD = 25_000_002,
    parameter int TOL         = 1024,
    parameter int TIMEOUT     = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [1:0]       rate,
    output logic             lost
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [1:0] RATE_NONE = 2'b00;
    localparam logic [1:0] RATE_FAST = 2'b01;
    localparam logic [1:0] RATE_SLOW = 2'b10;
    localparam logic [1:0] RATE_OOR  = 2'b11;

    // Classification runs one bit wider than the counter so that count+1
    // and the subtraction never wrap.
    localparam logic [CNT_W:0]   FAST_N   = (CNT_W+1)'(FAST_PERIOD);
    localparam logic [CNT_W:0]   SLOW_N   = (CNT_W+1)'(SLOW_PERIOD);
    localparam logic [CNT_W:0]   TOL_N    = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // FSM state, kept as a named signal so checkers can bind to it.
    state_t state;

    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   meas;
    logic [CNT_W:0]   d_fast;
    logic [CNT_W:0]   d_slow;
    logic [1:0]       rate_next;

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a,
                                                input logic [CNT_W:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // s1/s2 resolve metastability; s3 is the previous synchronized level.
    assign rise = s2 & ~s3;

    always_comb begin
        meas      = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
        d_fast    = abs_diff(meas, FAST_N);
        d_slow    = abs_diff(meas, SLOW_N);
        rate_next = RATE_OOR;
        // Fast window is tested first so it wins if the windows overlap.
        if (d_fast <= TOL_N) begin
            rate_next = RATE_FAST;
        end else if (d_slow <= TOL_N) begin
            rate_next = RATE_SLOW;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            state        <= IDLE;
            count        <= CNT_ZERO;
            period       <= CNT_ZERO;
            period_valid <= 1'b0;
            rate         <= RATE_NONE;
            lost         <= 1'b0;
        end else begin
            s1           <= sig_in;
            s2           <= s1;
            s3           <= s2;
            period_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        // First edge only opens a measurement window.
                        count <= CNT_ZERO;
                        lost  <= 1'b0;
                        state <= MEASURE;
                    end else begin
                        if (count != TMO) begin
                            count <= count + CNT_ONE;
                        end
                        if ((count == TMO_M1) && !lost) begin
                            lost <= 1'b1;
                        end
                    end
                end

                MEASURE: begin
                    // An edge on the timeout cycle is still a valid
                    // measurement, so it is tested before the timeout.
                    if (rise) begin
                        period       <= meas[CNT_W-1:0];
                        rate         <= rate_next;
                        period_valid <= 1'b1;
                        count        <= CNT_ZERO;
                    end else if (count == TMO_M1) begin
                        lost  <= 1'b1;
                        rate  <= RATE_NONE;
                        count <= CNT_ZERO;
                        state <= IDLE;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_rate_meter.sv
// tb_pulse_rate_meter
//
// Directed bench for pulse_rate_meter with small parameters (CNT_W=8,
// FAST=20, SLOW=40, TOL=2, TIMEOUT=100). Expected strobes are pushed as
// {period, rate} into exp_q before the stimulus that produces them; a
// monitor pops one entry per period_valid and also checks the strobe
// latency against the last rising edge driven on sig_in.
//
// Cycle bookkeeping: cyc counts posedges. sig_in changes on a negedge, so the
// posedge that first samples it is cyc+1 (recorded as last_rise). The strobe
// is high after posedge last_rise+2 and is therefore sampled by posedge
// last_rise+3.

module tb_pulse_rate_meter;

    localparam int CNT_W       = 8;
    localparam int FAST_PERIOD = 20;
    localparam int SLOW_PERIOD = 40;
    localparam int TOL         = 2;
    localparam int TIMEOUT     = 100;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic sig_in = 1'b0;

    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [1:0]       rate;
    logic             lost;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    pulse_rate_meter #(
        .CNT_W      (CNT_W),
        .FAST_PERIOD(FAST_PERIOD),
        .SLOW_PERIOD(SLOW_PERIOD),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .period      (period),
        .period_valid(period_valid),
        .rate        (rate),
        .lost        (lost)
    );

    // ---------------- scoreboard ----------------
    int n_checks  = 0;
    int n_pass    = 0;
    int last_rise = -1000;
    int mark;

    logic [CNT_W+1:0] exp_q[$];
    logic [CNT_W+1:0] mon_e;

    task automatic chk(input string tag, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    task automatic push_exp(input int p, input int r);
        exp_q.push_back({p[CNT_W-1:0], r[1:0]});
    endtask

    always @(negedge clk) begin
        if (!reset && period_valid) begin
            chk("strobe_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("period", int'(period), int'(mon_e[CNT_W+1:2]));
                chk("rate", int'(rate), int'(mon_e[1:0]));
            end
            chk("strobe_latency", cyc + 1 - last_rise, 3);
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers are entered and left on a negedge.
    task automatic rise_now();
        sig_in    = 1'b1;
        last_rise = cyc + 1;
    endtask

    // n rising edges of a square wave toggling every h cycles.
    task automatic wave(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            rise_now();
            repeat (h) @(negedge clk);
            sig_in = 1'b0;
            repeat (h) @(negedge clk);
        end
    endtask

    // One-cycle-wide high pulse, next rise allowed gap cycles later.
    task automatic pulse(input int gap);
        rise_now();
        @(negedge clk);
        sig_in = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
        chk("wait_target", cyc, c);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_valid"}, int'(period_valid), 0);
        chk({tag, "_rate"}, int'(rate), 0);
        chk({tag, "_lost"}, int'(lost), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        @(negedge clk);

        // Reset held while sig_in toggles: everything stays at zero.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sig_in = ~sig_in;
            if (i == 4 || i == 9) chk_zero_outputs("in_reset");
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // First edge opens the window; then fast, slow, edge of slow window,
        // just outside, out of range, back to fast.
        push_exp(20, 1); push_exp(20, 1); push_exp(20, 1);
        wave(10, 4);
        push_exp(20, 1); push_exp(40, 2); push_exp(40, 2);
        wave(20, 3);
        push_exp(40, 2); push_exp(42, 2);
        wave(21, 2);
        push_exp(42, 2); push_exp(44, 3);
        wave(22, 2);
        push_exp(44, 3); push_exp(30, 3);
        wave(15, 2);
        push_exp(30, 3); push_exp(20, 1); push_exp(20, 1);
        wave(10, 3);

        // Input stops: loss exactly TIMEOUT cycles after the registered edge.
        mark = last_rise;
        wait_cyc(mark + 101);
        chk("lost_before_timeout", int'(lost), 0);
        @(negedge clk);
        chk("lost_at_timeout", int'(lost), 1);
        chk("rate_at_loss", int'(rate), 0);
        chk("period_held", int'(period), 20);

        // Recovery edge clears lost without a strobe.
        rise_now();
        mark = last_rise;
        @(negedge clk);
        @(negedge clk);
        chk("lost_before_clear", int'(lost), 1);
        @(negedge clk);
        chk("lost_cleared", int'(lost), 0);
        repeat (7) @(negedge clk);
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        push_exp(20, 1); push_exp(20, 1);
        wave(10, 2);

        // Reset in the middle of a measurement (counter at 37).
        mark = last_rise;
        wait_cyc(mark + 39);
        reset = 1'b1;
        #1;
        chk_zero_outputs("mid_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wave(10, 1);
        chk("after_reset_first_edge_period", int'(period), 0);
        chk("after_reset_first_edge_rate", int'(rate), 0);
        push_exp(20, 1); push_exp(20, 1);
        wave(10, 2);

        // Single-cycle pulses still register as rising edges.
        push_exp(20, 1); push_exp(30, 3);
        pulse(30);
        pulse(30);

        // Edge landing on the timeout cycle is a measurement, not a loss.
        push_exp(100, 3);
        mark = last_rise;
        wait_cyc(mark + 99);
        rise_now();
        mark = last_rise;
        wait_cyc(mark + 2);
        chk("coincident_lost", int'(lost), 0);
        chk("coincident_period", int'(period), 100);
        chk("coincident_rate", int'(rate), 3);
        repeat (5) @(negedge clk);
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("coincident_lost_after", int'(lost), 0);
        chk("queue_drained", int'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
